masked_iter_ctrl: RTL and testbench

MASKED_ITER_CTRL -- requirements
Module: masked_iter_ctrl

---
 rtl/masked_iter_ctrl.sv | 161 ++++++++++++++++
 tb/tb_masked_iter_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_iter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// masked_iter_ctrl : iteration controller for an external masked round datapath
// Rev 1.0
// ---------------------------------------------------------------------------
module masked_iter_ctrl #(
    parameter int SHARES = 3,
    parameter int WIDTH  = 64,
    parameter int ROUNDS = 12,
    parameter int STAGES = 2,
    parameter int RAND_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    enc_dec,
    input  logic [SHARES*WIDTH-1:0] in_shares,
    input  logic                    seed_load,
    input  logic [RAND_W-1:0]       seed,
    input  logic [SHARES*WIDTH-1:0] dp_in,
    output logic [SHARES*WIDTH-1:0] state_shares,
    output logic [4:0]              rnd_idx,
    output logic                    stage_en,
    output logic [RAND_W-1:0]       fresh_r,
    output logic [SHARES*WIDTH-1:0] out_shares,
    output logic                    busy,
    output logic                    done
);

    localparam int c_SCNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [c_SCNT_W-1:0] c_LAST_STAGE = c_SCNT_W'(STAGES - 1);
    localparam logic [4:0]          c_LAST_IDX   = 5'(ROUNDS - 1);

    // Right-shifting Galois feedback masks for maximal-length polynomials.
    function automatic logic [RAND_W-1:0] lfsr_poly(input int w);
        case (w)
            8:       lfsr_poly = RAND_W'(64'h0000_0000_0000_00B8);
            16:      lfsr_poly = RAND_W'(64'h0000_0000_0000_B400);
            24:      lfsr_poly = RAND_W'(64'h0000_0000_00E1_0000);
            32:      lfsr_poly = RAND_W'(64'h0000_0000_8020_0003);
            64:      lfsr_poly = RAND_W'(64'hD800_0000_0000_0000);
            default: lfsr_poly = RAND_W'(64'h0000_0000_8020_0003);
        endcase
    endfunction

    localparam logic [RAND_W-1:0] c_POLY = lfsr_poly(RAND_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [SHARES*WIDTH-1:0]   r_state_sh;
    logic [SHARES*WIDTH-1:0]   r_out_sh;
    logic [4:0]                r_rnd_idx;
    logic [c_SCNT_W-1:0]       r_stage_cnt;
    logic                      r_dec;
    logic [RAND_W-1:0]         r_lfsr;
    logic [RAND_W-1:0]         w_lfsr_step;
    logic                      w_stage_last;
    logic                      w_round_last;
    logic                      w_busy;
    logic                      w_done;
    logic                      w_stage_en;

    assign w_stage_last = (r_stage_cnt == c_LAST_STAGE);
    assign w_round_last = r_dec ? (r_rnd_idx == 5'd0) : (r_rnd_idx == c_LAST_IDX);
    assign w_lfsr_step  = {1'b0, r_lfsr[RAND_W-1:1]} ^ (r_lfsr[0] ? c_POLY : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_stage_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                w_busy     = 1'b1;
                w_stage_en = 1'b1;
                if (w_stage_last && w_round_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The index is held on the final load so it never leaves 0..ROUNDS-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_sh  <= '0;
            r_out_sh    <= '0;
            r_rnd_idx   <= 5'd0;
            r_stage_cnt <= '0;
            r_dec       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state_sh  <= in_shares;
                        r_dec       <= enc_dec;
                        r_rnd_idx   <= enc_dec ? c_LAST_IDX : 5'd0;
                        r_stage_cnt <= '0;
                    end
                end
                S_ROUND: begin
                    r_stage_cnt <= w_stage_last ? '0 : r_stage_cnt + 1'b1;
                    if (w_stage_last) begin
                        r_state_sh <= dp_in;
                        if (w_round_last) begin
                            r_out_sh <= dp_in;
                        end else begin
                            r_rnd_idx <= r_dec ? r_rnd_idx - 5'd1 : r_rnd_idx + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= RAND_W'(1);
        end else if (seed_load) begin
            r_lfsr <= (seed == '0) ? RAND_W'(1) : seed;
        end else if (r_state == S_ROUND) begin
            r_lfsr <= w_lfsr_step;
        end
    end

    assign state_shares = r_state_sh;
    assign rnd_idx      = r_rnd_idx;
    assign stage_en     = w_stage_en;
    assign fresh_r      = r_lfsr;
    assign out_shares   = r_out_sh;
    assign busy         = w_busy;
    assign done         = w_done;

endmodule
`default_nettype wire

// File: tb/tb_masked_iter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_masked_iter_ctrl : randomized self-checking bench with a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_masked_iter_ctrl;

    localparam int SHARES = 3;
    localparam int WIDTH  = 64;
    localparam int ROUNDS = 12;
    localparam int STAGES = 2;
    localparam int RAND_W = 32;
    localparam int SW     = SHARES * WIDTH;
    localparam int c_LAT  = ROUNDS * STAGES + 1;
    localparam logic [RAND_W-1:0] c_POLY   = 32'h8020_0003;
    localparam logic [WIDTH-1:0]  c_TARGET = 64'h0123_4567_89AB_CDEF;
    localparam logic [WIDTH-1:0]  c_RESULT = 64'h0123_4567_89AB_CDE3;

    logic              clk;
    logic              reset;
    logic              start;
    logic              enc_dec;
    logic              seed_load;
    logic [RAND_W-1:0] seed;
    logic [SW-1:0]     in_shares;
    logic [SW-1:0]     dp_in;
    logic [SW-1:0]     state_shares;
    logic [SW-1:0]     out_shares;
    logic [4:0]        rnd_idx;
    logic [RAND_W-1:0] fresh_r;
    logic              stage_en;
    logic              busy;
    logic              done;

    int            n_checks  = 0;
    int            n_errors  = 0;
    bit            rand_seed = 1'b0;
    logic [SW-1:0] last_out  = '0;

    masked_iter_ctrl #(
        .SHARES(SHARES), .WIDTH(WIDTH), .ROUNDS(ROUNDS), .STAGES(STAGES), .RAND_W(RAND_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .enc_dec(enc_dec),
        .in_shares(in_shares), .seed_load(seed_load), .seed(seed), .dp_in(dp_in),
        .state_shares(state_shares), .rnd_idx(rnd_idx), .stage_en(stage_en),
        .fresh_r(fresh_r), .out_shares(out_shares), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round datapath stand-in: share 0 XOR (round index + 1).
    always_comb begin
        dp_in            = state_shares;
        dp_in[WIDTH-1:0] = state_shares[WIDTH-1:0] ^ WIDTH'(rnd_idx + 5'd1);
    end

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RAND_W-1:0] lfsr_next(input logic [RAND_W-1:0] v);
        return v[0] ? ((v >> 1) ^ c_POLY) : (v >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] share_xor(input logic [SW-1:0] v);
        logic [WIDTH-1:0] x = '0;
        for (int s = 0; s < SHARES; s++) x ^= v[s*WIDTH +: WIDTH];
        return x;
    endfunction

    function automatic logic [SW-1:0] model_result(input logic [SW-1:0] sh, input logic dec);
        logic [SW-1:0] r = sh;
        for (int i = 0; i < ROUNDS; i++) begin
            int idx = dec ? ROUNDS - 1 - i : i;
            r[WIDTH-1:0] ^= WIDTH'(idx + 1);
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] rand_sh();
        logic [SW-1:0] v;
        for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: an operation is ROUNDS*STAGES busy cycles then one done cycle.
    logic [RAND_W-1:0] m_lfsr = RAND_W'(1);
    int                m_left = 0;
    bit                m_done = 1'b0;
    bit                m_dec  = 1'b0;

    always @(negedge clk) begin
        int k;
        if (!reset) begin
            m_lfsr = RAND_W'(1);
            m_left = 0;
            m_done = 1'b0;
        end
        check("status", SW'({busy, done, stage_en}),
              SW'({(m_left > 0) || m_done, m_done, m_left > 0}));
        check("fresh_r", SW'(fresh_r), SW'(m_lfsr));
        if (m_left > 0) begin
            k = (ROUNDS * STAGES - m_left) / STAGES;
            check("rnd_idx", SW'(rnd_idx), SW'(m_dec ? ROUNDS - 1 - k : k));
        end
        if (reset) begin
            if (seed_load)       m_lfsr = (seed == '0) ? RAND_W'(1) : seed;
            else if (m_left > 0) m_lfsr = lfsr_next(m_lfsr);
            if (m_left > 0) begin
                m_left--;
                m_done = (m_left == 0);
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (start) begin
                m_left = ROUNDS * STAGES;
                m_dec  = enc_dec;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_seed) begin
            seed_load = ($urandom_range(0, 7) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? '0 : RAND_W'($urandom);
        end
    endtask

    task automatic wait_done(input logic [SW-1:0] hold, output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 10) check("out_hold", out_shares, hold);
        end while (done !== 1'b1 && n < 200);
    endtask

    task automatic post_done(input logic [SW-1:0] sh, input logic dec, input string tag);
        logic [SW-1:0] exp;
        exp = model_result(sh, dec);
        check({tag, "_out"}, out_shares, exp);
        check({tag, "_xor"}, SW'(share_xor(out_shares)), SW'(share_xor(sh) ^ WIDTH'(12)));
        last_out = exp;
        tick();
        check({tag, "_state_hold"}, state_shares, exp);
    endtask

    task automatic do_op(input logic [SW-1:0] sh, input logic dec, input string tag);
        int n;
        in_shares = sh;
        enc_dec   = dec;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        in_shares = rand_sh();
        enc_dec   = ~dec;
        wait_done(last_out, n);
        check({tag, "_lat"}, SW'(n + 1), SW'(c_LAT));
        post_done(sh, dec, tag);
    endtask

    initial begin
        logic [SW-1:0]     sh;
        logic [WIDTH-1:0]  s1, s2;
        logic [RAND_W-1:0] lf;
        int                n, m, nd;

        reset = 1'b0; start = 1'b0; enc_dec = 1'b0; in_shares = '0;
        seed_load = 1'b0; seed = '0;
        repeat (3) tick();
        check("rst_state", state_shares, '0);
        check("rst_out", out_shares, '0);
        check("rst_idx", SW'(rnd_idx), '0);
        reset = 1'b1;
        tick();

        // Seed handling, then three ROUND cycles of LFSR advance.
        seed_load = 1'b1; seed = '0;
        tick();
        check("seed_zero", SW'(fresh_r), SW'(1));
        seed = 32'h0000_ACE1;
        tick();
        seed_load = 1'b0;
        lf = 32'h0000_ACE1;
        repeat (3) lf = lfsr_next(lf);
        sh = SW'(c_TARGET);
        in_shares = sh; enc_dec = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("lfsr_3step", SW'(fresh_r), SW'(lf));
        wait_done(last_out, m);
        check("seed_lat", SW'(m + 4), SW'(c_LAT));
        post_done(sh, 1'b0, "seed_op");

        do_op(SW'(c_TARGET), 1'b0, "enc");
        check("enc_const", SW'(share_xor(out_shares)), SW'(c_RESULT));
        do_op(SW'(c_TARGET), 1'b1, "dec");
        check("dec_const", SW'(share_xor(out_shares)), SW'(c_RESULT));

        // start held high: back-to-back operations, no early restart.
        sh = rand_sh();
        in_shares = sh; enc_dec = 1'b0; start = 1'b1;
        tick();
        wait_done(last_out, n);
        check("held_lat", SW'(n + 1), SW'(c_LAT));
        check("held_out1", out_shares, model_result(sh, 1'b0));
        last_out = model_result(sh, 1'b0);
        wait_done(last_out, m);
        check("held_period", SW'(m), SW'(c_LAT + 1));
        start = 1'b0;
        check("held_out2", out_shares, model_result(sh, 1'b0));
        tick();

        // Randomly masked target with random seeding activity.
        rand_seed = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s1 = {$urandom, $urandom};
            s2 = {$urandom, $urandom};
            sh = {s2, s1, c_TARGET ^ s1 ^ s2};
            do_op(sh, 1'($urandom_range(0, 1)), "masked");
            check("masked_const", SW'(share_xor(out_shares)), SW'(c_RESULT));
        end
        rand_seed = 1'b0;
        seed_load = 1'b0;
        tick();

        // Reset in the middle of an operation.
        in_shares = rand_sh(); enc_dec = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check("abort_state", state_shares, '0);
        check("abort_out", out_shares, '0);
        check("abort_idx", SW'(rnd_idx), '0);
        check("abort_ctl", SW'({busy, done, stage_en}), '0);
        check("abort_lfsr", SW'(fresh_r), SW'(1));
        repeat (2) tick();
        reset = 1'b1;
        nd = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) nd++;
        end
        check("abort_nodone", SW'(nd), '0);
        check("abort_out_kept", out_shares, '0);
        last_out = '0;
        do_op(SW'(c_TARGET), 1'b1, "post_rst");
        check("post_rst_const", SW'(share_xor(out_shares)), SW'(c_RESULT));

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
